// File: rtl/gba_gpu_pkg.sv
// Shared types and constants for the GPU framebuffer write stage.
package gba_gpu_pkg;

    localparam int unsigned RGB_CH_W = 6;
    localparam int unsigned FB_WORDS = 38400;

    typedef struct packed {
        logic [15:0] addr;
        logic [17:0] data;
    } fb_pix_t;

    typedef enum logic [1:0] {IDLE, RD, WR} fbw_state_t;

    // Per-channel rounded average: (old + cur + 1) >> 1 with a 7-bit intermediate.
    function automatic logic [17:0] blend_rgb6(input logic [17:0] old_px,
                                               input logic [17:0] cur_px);
        logic [17:0]         res;
        logic [RGB_CH_W:0]   sum;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            sum = {1'b0, old_px[c*RGB_CH_W +: RGB_CH_W]} + {1'b0, cur_px[c*RGB_CH_W +: RGB_CH_W]}
                  + 7'd1;
            res[c*RGB_CH_W +: RGB_CH_W] = sum[RGB_CH_W:1];
        end
        return res;
    endfunction

endpackage

// File: rtl/gba_gpu_fbwrite_if.sv
// Pixel-stream and framebuffer-memory signals of the write stage.
// slave: the write stage itself; master: pixel source plus memory controller.
interface gba_gpu_fbwrite_if;
    logic [15:0] pixel_in_addr;
    logic [17:0] pixel_in_data;
    logic        pixel_in_we;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [17:0] mem_wdata;
    logic [17:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  pixel_in_addr, pixel_in_data, pixel_in_we, mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output pixel_in_addr, pixel_in_data, pixel_in_we, mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/gba_gpu_fbwrite_fifo.sv
// Pixel FIFO with first-word-fall-through head; also exposes the entry behind
// the head so the write FSM can chain transactions without a bubble.
module gba_gpu_fbwrite_fifo
    import gba_gpu_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  fb_pix_t                 push_pix_i,
    input  logic                    pop_i,
    output fb_pix_t                 head_o,
    output fb_pix_t                 head_nxt_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   PtrOne  = 1;
    localparam logic [AW-1:0] IdxOne  = 1;
    localparam logic [AW:0]   FullLvl = DEPTH[AW:0];

    fb_pix_t       mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW-1:0] rd_nxt_idx;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_pix_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    assign rd_nxt_idx = rd_ptr_q[AW-1:0] + IdxOne;
    assign head_o     = mem_q[rd_ptr_q[AW-1:0]];
    assign head_nxt_o = mem_q[rd_nxt_idx];
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign full_o     = (level_o == FullLvl);
    assign empty_o    = (level_o == '0);

endmodule

// File: rtl/gba_gpu_fbwrite.sv
// Framebuffer write stage: buffers the shaded pixel stream and retires it via req/ack.
// Optional read-modify-write frame blend is built when GBA_FBWRITE_BLEND_EN is defined.
module gba_gpu_fbwrite
    import gba_gpu_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    fclk,
    input  logic                    resetn,
    gba_gpu_fbwrite_if.slave        bus,
    input  logic                    blend_on,
    input  logic                    stat_clr,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    output logic [CNT_W-1:0]        drop_count,
    output logic                    busy
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]    LvlOne = 1;
    localparam logic [CNT_W-1:0] CntOne = 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    fb_pix_t    push_pix, head, head_nxt;
    logic       full, empty, push, pop, drop, more, blend_act;
    fbw_state_t state_q;
    logic       mem_req_q, mem_we_q;
    logic [15:0] mem_addr_q;
    logic [17:0] mem_wdata_q;
    logic        overflow_q;
    logic [CNT_W-1:0] drop_count_q;

`ifdef GBA_FBWRITE_BLEND_EN
    assign blend_act = blend_on;
`else
    logic unused_ok;
    assign blend_act = 1'b0;
    assign unused_ok = ^{blend_on, bus.mem_rdata};
`endif

    // A full FIFO still accepts a pixel when the head retires in the same cycle.
    assign pop      = (state_q == WR) && bus.mem_ack;
    assign push     = bus.pixel_in_we && (!full || pop);
    assign drop     = bus.pixel_in_we && full && !pop;
    assign more     = (fifo_level > LvlOne);
    assign push_pix = '{addr: bus.pixel_in_addr, data: bus.pixel_in_data};

    gba_gpu_fbwrite_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (fclk),
        .rst_ni     (resetn),
        .push_i     (push),
        .push_pix_i (push_pix),
        .pop_i      (pop),
        .head_o     (head),
        .head_nxt_o (head_nxt),
        .full_o     (full),
        .empty_o    (empty),
        .level_o    (fifo_level)
    );

    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= !blend_act;
                        mem_addr_q  <= head.addr;
                        mem_wdata_q <= head.data;
                        state_q     <= blend_act ? RD : WR;
                    end
                end
`ifdef GBA_FBWRITE_BLEND_EN
                RD: begin
                    if (bus.mem_ack) begin
                        mem_wdata_q <= blend_rgb6(bus.mem_rdata, mem_wdata_q);
                        mem_we_q    <= 1'b1;
                        state_q     <= WR;
                    end
                end
`endif
                WR: begin
                    if (bus.mem_ack) begin
                        if (more) begin
                            mem_we_q    <= !blend_act;
                            mem_addr_q  <= head_nxt.addr;
                            mem_wdata_q <= head_nxt.data;
                            state_q     <= blend_act ? RD : WR;
                        end else begin
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (stat_clr) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != CntMax) drop_count_q <= drop_count_q + CntOne;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_count_q;
    assign busy          = !empty || mem_req_q;

endmodule

// File: tb/tb_gba_gpu_fbwrite.sv
// Directed bench for gba_gpu_fbwrite; blend scenario runs when GBA_FBWRITE_BLEND_EN is defined.
module tb_gba_gpu_fbwrite;
    logic fclk = 1'b0;
    logic resetn = 1'b0;
    always #5 fclk = ~fclk;

    logic        blend_on, stat_clr, stat_clr2;
    logic [3:0]  fifo_level, fifo_level2;
    logic        overflow, overflow2, busy, busy2;
    logic [15:0] drop_count;
    logic [3:0]  drop_count2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] wq_addr[$];
    logic [17:0] wq_data[$];

    gba_gpu_fbwrite_if bus ();
    gba_gpu_fbwrite_if bus2 ();

    gba_gpu_fbwrite #(.DEPTH(8), .CNT_W(16)) u_dut (
        .fclk       (fclk),
        .resetn     (resetn),
        .bus        (bus),
        .blend_on   (blend_on),
        .stat_clr   (stat_clr),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .busy       (busy)
    );

    gba_gpu_fbwrite #(.DEPTH(8), .CNT_W(4)) u_sat (
        .fclk       (fclk),
        .resetn     (resetn),
        .bus        (bus2),
        .blend_on   (1'b0),
        .stat_clr   (stat_clr2),
        .fifo_level (fifo_level2),
        .overflow   (overflow2),
        .drop_count (drop_count2),
        .busy       (busy2)
    );

    always @(posedge fclk) begin
        if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
            wq_addr.push_back(bus.mem_addr);
            wq_data.push_back(bus.mem_wdata);
        end
    end

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic test_reset();
        n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
        n_tests++; if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 18'h0) begin
            n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
        n_tests++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_tests++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_stats: got %b/%0d want 0/0", overflow, drop_count); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        wq_addr.delete(); wq_data.delete();
        bus.pixel_in_addr = 16'h0010; bus.pixel_in_data = 18'h3F000; bus.pixel_in_we = 1'b1;
        tick();
        bus.pixel_in_we = 1'b0;
        n_tests++; if (fifo_level !== 4'd1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_push: level/busy got %0d/%b want 1/1", fifo_level, busy); end
        n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL single_req_n1: got %b want 0", bus.mem_req); end
        tick();
        n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
            n_fail++; $display("FAIL single_req_n2: req/we got %b/%b want 1/1", bus.mem_req, bus.mem_we); end
        n_tests++; if (bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 18'h3F000) begin
            n_fail++; $display("FAIL single_addr_data: got %h/%h want 0010/3f000", bus.mem_addr, bus.mem_wdata); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        n_tests++; if (bus.mem_req !== 1'b0 || busy !== 1'b0 || fifo_level !== 4'd0) begin
            n_fail++; $display("FAIL single_done: req/busy/level got %b/%b/%0d want 0/0/0", bus.mem_req, busy, fifo_level); end
        repeat (4) tick();
        n_tests++; if (wq_addr.size() != 1 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL single_count: got %0d writes req=%b want 1 write req=0", wq_addr.size(), bus.mem_req);
        end else if (wq_addr[0] !== 16'h0010 || wq_data[0] !== 18'h3F000) begin
            n_fail++; $display("FAIL single_write: got %h/%h want 0010/3f000", wq_addr[0], wq_data[0]);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 12; i++) begin
            bus.pixel_in_addr = 16'h0100 + 16'(i);
            bus.pixel_in_data = 18'h01000 + 18'(i);
            bus.pixel_in_we   = 1'b1;
            tick();
        end
        bus.pixel_in_we = 1'b0;
        repeat (20) tick();
        n_tests++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
        n_tests++; if (overflow !== 1'b1 || drop_count !== 16'd4) begin
            n_fail++; $display("FAIL ovf_stats: got %b/%0d want 1/4", overflow, drop_count); end
        n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0100 || bus.mem_wdata !== 18'h01000) begin
            n_fail++; $display("FAIL ovf_hold: got req=%b %h/%h want 1 0100/01000", bus.mem_req, bus.mem_addr, bus.mem_wdata); end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_tests++; if (overflow !== 1'b0 || drop_count !== 16'd0 || fifo_level !== 4'd8) begin
            n_fail++; $display("FAIL ovf_clr: got %b/%0d level %0d want 0/0 level 8", overflow, drop_count, fifo_level); end
    endtask

    // Continues from the full FIFO left by test_overflow.
    task automatic test_full_push_pop();
        int n;
        wq_addr.delete(); wq_data.delete();
        bus.pixel_in_addr = 16'h01FF; bus.pixel_in_data = 18'h2AAAA; bus.pixel_in_we = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        bus.pixel_in_we = 1'b0;
        n_tests++; if (fifo_level !== 4'd8 || overflow !== 1'b0 || drop_count !== 16'd0) begin
            n_fail++; $display("FAIL full_pushpop: level/ovf/drop got %0d/%b/%0d want 8/0/0", fifo_level, overflow, drop_count); end
        n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0101) begin
            n_fail++; $display("FAIL full_next: req/addr got %b/%h want 1/0101", bus.mem_req, bus.mem_addr); end
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        bus.mem_ack = 1'b0;
        n_tests++; if (n != 8) begin n_fail++; $display("FAIL drain_cycles: got %0d want 8", n); end
        n_tests++; if (wq_addr.size() != 9) begin
            n_fail++; $display("FAIL drain_count: got %0d want 9", wq_addr.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                logic [15:0] ea;
                logic [17:0] ed;
                ea = (i < 8) ? 16'h0100 + 16'(i) : 16'h01FF;
                ed = (i < 8) ? 18'h01000 + 18'(i) : 18'h2AAAA;
                n_tests++;
                if (wq_addr[i] !== ea || wq_data[i] !== ed) begin
                    n_fail++; $display("FAIL drain_order[%0d]: got %h/%h want %h/%h", i, wq_addr[i], wq_data[i], ea, ed);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        wq_addr.delete(); wq_data.delete();
        bus.mem_ack = 1'b1;
        bus.pixel_in_addr = 16'h0020; bus.pixel_in_data = 18'h00001; bus.pixel_in_we = 1'b1;
        tick();
        bus.pixel_in_data = 18'h00002;
        tick();
        bus.pixel_in_we = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        bus.mem_ack = 1'b0;
        n_tests++; if (wq_addr.size() != 2) begin
            n_fail++; $display("FAIL dup_count: got %0d want 2", wq_addr.size());
        end else if (wq_addr[0] !== 16'h0020 || wq_data[0] !== 18'h00001 ||
                     wq_addr[1] !== 16'h0020 || wq_data[1] !== 18'h00002) begin
            n_fail++; $display("FAIL dup_order: got %h/%h %h/%h want 0020/00001 0020/00002",
                               wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
        end
    endtask

`ifdef GBA_FBWRITE_BLEND_EN
    task automatic blend_one(input logic [15:0] a, input logic [17:0] cur,
                             input logic [17:0] old, input logic [17:0] exp_px);
        blend_on = 1'b1;
        bus.pixel_in_addr = a; bus.pixel_in_data = cur; bus.pixel_in_we = 1'b1;
        tick();
        bus.pixel_in_we = 1'b0;
        tick();
        n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== a) begin
            n_fail++; $display("FAIL blend_rd: req/we/addr got %b/%b/%h want 1/0/%h", bus.mem_req, bus.mem_we, bus.mem_addr, a); end
        bus.mem_rdata = old; bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== a || bus.mem_wdata !== exp_px) begin
            n_fail++; $display("FAIL blend_wr: req/we/addr/data got %b/%b/%h/%h want 1/1/%h/%h",
                               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, a, exp_px); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        blend_on = 1'b0;
        n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL blend_done: req got %b want 0", bus.mem_req); end
    endtask

    task automatic test_blend();
        blend_one(16'h0030, 18'h3FFFF, 18'h00000, 18'h20820);
        blend_one(16'h0031, 18'h3F040, 18'h3F000, 18'h3F040);
    endtask
`endif

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            bus.pixel_in_addr = 16'h0040 + 16'(i); bus.pixel_in_data = 18'h00100; bus.pixel_in_we = 1'b1;
            tick();
        end
        bus.pixel_in_we = 1'b0;
        n_tests++; if (bus.mem_req !== 1'b1 || fifo_level !== 4'd3) begin
            n_fail++; $display("FAIL rstmid_pre: req/level got %b/%0d want 1/3", bus.mem_req, fifo_level); end
        #2;
        resetn = 1'b0;
        #1;
        n_tests++; if (bus.mem_req !== 1'b0 || fifo_level !== 4'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: req/level/busy got %b/%0d/%b want 0/0/0", bus.mem_req, fifo_level, busy); end
        tick();
        resetn = 1'b1;
        repeat (5) tick();
        n_tests++; if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_after: req/busy got %b/%b want 0/0", bus.mem_req, busy); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 28; i++) begin
            bus2.pixel_in_addr = 16'(i); bus2.pixel_in_data = 18'(i); bus2.pixel_in_we = 1'b1;
            tick();
        end
        bus2.pixel_in_we = 1'b0;
        tick();
        n_tests++; if (drop_count2 !== 4'd15 || overflow2 !== 1'b1 || fifo_level2 !== 4'd8) begin
            n_fail++; $display("FAIL sat_count: drop/ovf/level got %0d/%b/%0d want 15/1/8", drop_count2, overflow2, fifo_level2); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pixel_in_addr = '0; bus.pixel_in_data = '0; bus.pixel_in_we = 1'b0;
        bus.mem_rdata = '0; bus.mem_ack = 1'b0;
        bus2.pixel_in_addr = '0; bus2.pixel_in_data = '0; bus2.pixel_in_we = 1'b0;
        bus2.mem_rdata = '0; bus2.mem_ack = 1'b0;
        blend_on = 1'b0; stat_clr = 1'b0; stat_clr2 = 1'b0;
        repeat (2) tick();
        test_reset();
        resetn = 1'b1;
        tick();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
`ifdef GBA_FBWRITE_BLEND_EN
        test_blend();
`endif
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gba_gpu_fbwrite.md
# gba_gpu_fbwrite

Framebuffer write stage directly downstream of the GPU colour-shading pipeline. It accepts the shaded RGB6 pixel stream (address, 18-bit data, write-enable), buffers it in a small FIFO, and retires each pixel to framebuffer memory through a req/ack port. It decouples the fixed-rate pixel pipeline from memory stalls and reports overflow, since the pixel stream cannot be back-pressured.

## Interface
- DEPTH, 8: FIFO entries; power of two, 4..64.
- CNT_W, 16: width of the saturating drop counter.

- fclk  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pixel_in_addr  in  16  framebuffer word address (y*240+x).
- pixel_in_data  in  18  RGB6 colour: R[17:12], G[11:6], B[5:0].
- pixel_in_we  in  1  pixel valid this cycle; no back-pressure.
- blend_on  in  1  runtime frame-blend enable; honoured only when the blend feature is compiled in.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  16  request address.
- mem_wdata  out  18  write data.
- mem_rdata  in  18  read data; valid in the cycle mem_ack is high for a read.
- mem_ack  in  1  one-cycle completion; sampled only while mem_req=1.
- stat_clr  in  1  synchronous clear of overflow and drop_count.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: at least one pixel was dropped.
- drop_count  out  CNT_W  dropped pixels; saturates at all-ones.
- busy  out  1  FIFO non-empty or a transaction is in flight.

## Operation
- Push: when pixel_in_we=1 and the FIFO is not full, or full with a pop in the same cycle, store {addr,data}.
  - When full with no pop, drop the pixel: set overflow and increment drop_count (saturating).
  - stat_clr has priority over a same-cycle drop increment.
- FSM states: IDLE, RD (blend only), WR.
- IDLE: if the FIFO is non-empty, load the head into mem_addr/mem_wdata.
  - Go to RD when blending is active; otherwise go to WR.
  - mem_req rises on that edge.
- RD: mem_we=0.
  - On mem_ack, per 6-bit channel: new=(old+cur+1)>>1, with a 7-bit intermediate sum. This gives 63+63 → 63 and 0+1 → 1.
  - Load the result into mem_wdata, then go to WR.
  - mem_req stays high and mem_we goes to 1 on the next cycle.
- WR: mem_we=1.
  - On mem_ack, pop the FIFO.
  - If the FIFO still holds a further entry, present it on the next cycle (to RD or WR) without dropping mem_req. Otherwise drop mem_req and go to IDLE.
- mem_req, mem_we, mem_addr and mem_wdata are registered, and must hold stable while mem_req=1 until ack.
- A blend_on change takes effect at the next IDLE→request or WR→next-entry decision. It never applies mid-transaction.
- Address order is preserved. Duplicate addresses are written in order with no merging.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fifo_level=0, overflow=0, drop_count=0, busy=0. FSM=IDLE.
- Reset mid-transaction: the FIFO is emptied and mem_req drops asynchronously. The memory controller must tolerate an abandoned request.
- Latency with an empty FIFO: pixel_in_we in cycle N → mem_req=1 in cycle N+2. The push lands at edge N, and the IDLE decision at edge N+1.
- Throughput without blend: 1 pixel per cycle while mem_ack is held high. With blend: 1 pixel per 2 acks.
- fifo_level updates on the edge after the push or pop. A simultaneous push and pop leaves it unchanged.
- busy=1 from the push edge until the final WR ack edge.

## Configuration
- GBA_FBWRITE_BLEND_EN defined: the RD state, blend arithmetic and mem_rdata path are built. The blend_on input selects read-modify-write or plain write.
- Not defined: the RD state and blend datapath are absent and blend_on and mem_rdata are ignored. mem_we=1 whenever mem_req=1.

## Structure
- gba_gpu_pkg holds:
  - the RGB6 channel width constant (6);
  - the framebuffer word count (38400);
  - the typedef fb_pix_t {addr[15:0], data[17:0]};
  - the enum fbw_state_t {IDLE, RD, WR}.
- Sub-module gba_gpu_fbwrite_fifo: synchronous FIFO of fb_pix_t with push, pop, full, empty, level and first-word-fall-through head. The top level holds the FSM, blend datapath and statistics.

## Test plan
- Single pixel addr=0x0010, data=0x3F000, mem_ack one cycle after req → exactly one write with that addr/data, mem_req rising in N+2, busy falling after the ack.
- DEPTH=8, 12 consecutive pixels, mem_ack held low for 20 cycles → 8 retained in order, overflow=1, drop_count=4. stat_clr → both zero.
- FIFO full, with pixel_in_we and a WR ack in the same cycle → the pixel is accepted and fifo_level stays 8.
- Blend build, blend_on=1, mem_rdata=0x00000, new pixel 0x3FFFF → read then write of data 0x20820 (32,32,32) to the same addr.
- Reset asserted while mem_req=1 with 3 entries queued → mem_req=0 immediately, fifo_level=0, and after release no request is issued.
- drop_count preset near saturation (CNT_W=4, 20 drops) → drop_count=15, with no wrap.
